ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, directly downstream of the control decoder.
- Consumes the decoder's we_control, mem_control and exe_control, plus ID/EX operands.
- Performs ALU ops, beq compare and branch target, and EX/MEM-result forwarding.
- Registers everything into the EX/MEM pipeline register.
- Flags load-use hazards to the upstream stall logic.

---
 rtl/mips_pkg.sv | 17 +
 rtl/alu_core.sv | 18 +
 rtl/ex_stage.sv | 88 ++++++++
 tb/tb_ex_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: alu_op codes and control-bus bit positions shared by decoder and execute stage
package mips_pkg;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_BEQ = 3'b110;
  localparam int EXE_REGDST = 0;
  localparam int EXE_ALUSRC = 1;
  localparam int EXE_OP_LO  = 2;
  localparam int EXE_OP_HI  = 4;
  localparam int MEM_WR = 0;
  localparam int MEM_RD = 1;
  function automatic logic alu_legal(input logic [2:0] op);
    return op == ALU_ADD || op == ALU_SUB || op == ALU_AND || op == ALU_OR || op == ALU_BEQ;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational add/sub/and/or with zero flag; beq reuses subtraction
module alu_core import mips_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  always_comb begin
    result = alu_op == ALU_ADD ? a + b :
             (alu_op == ALU_SUB || alu_op == ALU_BEQ) ? a - b :
             alu_op == ALU_AND ? a & b :
             alu_op == ALU_OR  ? a | b : '0;
    zero = result == '0;
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with EX/MEM forwarding, beq resolution and the EX/MEM register
module ex_stage import mips_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              we_control,
  input  logic [1:0]        mem_control,
  input  logic [4:0]        exe_control,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic              exm_valid,
  output logic [DATA_W-1:0] exm_alu_result,
  output logic [DATA_W-1:0] exm_store_data,
  output logic [REG_AW-1:0] exm_wr_addr,
  output logic              exm_reg_write,
  output logic              exm_mem_rd,
  output logic              exm_mem_wr,
  output logic              exm_mem_to_reg,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              illegal_op,
  output logic              load_use_hazard
);
  logic [2:0]        alu_op;
  logic              is_beq, uses_rt, fwd_ok, valid, zero;
  logic [DATA_W-1:0] fwd_rs, fwd_rt, op_b, result;
  logic [REG_AW-1:0] wr_addr;
  always_comb begin
    alu_op  = exe_control[EXE_OP_HI:EXE_OP_LO];
    is_beq  = alu_op == ALU_BEQ;
    uses_rt = exe_control[EXE_REGDST] | mem_control[MEM_WR] | is_beq;
    // loads are excluded: their result is an address, not the value headed for the register
    fwd_ok  = exm_valid & exm_reg_write & ~exm_mem_to_reg & (exm_wr_addr != '0);
    fwd_rs  = (fwd_ok && exm_wr_addr == rs_addr) ? exm_alu_result : rs_data;
    fwd_rt  = (fwd_ok && exm_wr_addr == rt_addr) ? exm_alu_result : rt_data;
    op_b    = (exe_control[EXE_ALUSRC] && !is_beq) ? imm : fwd_rt;
    wr_addr = exe_control[EXE_REGDST] ? rd_addr : rt_addr;
    load_use_hazard = in_valid & exm_valid & exm_mem_rd & (exm_wr_addr != '0) &
                      ((exm_wr_addr == rs_addr) | ((exm_wr_addr == rt_addr) & uses_rt));
    valid = in_valid & ~load_use_hazard & alu_legal(alu_op);
  end
  alu_core #(.DATA_W(DATA_W)) u_alu (.alu_op(alu_op), .a(fwd_rs), .b(op_b), .result(result), .zero(zero));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm_valid      <= 1'b0;
      exm_alu_result <= '0;
      exm_store_data <= '0;
      exm_wr_addr    <= '0;
      exm_reg_write  <= 1'b0;
      exm_mem_rd     <= 1'b0;
      exm_mem_wr     <= 1'b0;
      exm_mem_to_reg <= 1'b0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
      illegal_op     <= 1'b0;
    end else if (flush) begin
      exm_valid      <= 1'b0;
      exm_reg_write  <= 1'b0;
      exm_mem_rd     <= 1'b0;
      exm_mem_wr     <= 1'b0;
      exm_mem_to_reg <= 1'b0;
      branch_taken   <= 1'b0;
      illegal_op     <= 1'b0;
    end else if (!stall) begin
      exm_valid      <= valid;
      exm_alu_result <= result;
      exm_store_data <= fwd_rt;
      exm_wr_addr    <= wr_addr;
      exm_reg_write  <= valid & ~mem_control[MEM_WR] & ~is_beq & (wr_addr != '0);
      exm_mem_rd     <= valid & mem_control[MEM_RD] & ~is_beq;
      exm_mem_wr     <= valid & mem_control[MEM_WR] & ~is_beq;
      exm_mem_to_reg <= valid & we_control;
      branch_taken   <= valid & is_beq & zero;
      branch_target  <= pc_plus4 + (imm << 2);
      illegal_op     <= in_valid & ~load_use_hazard & ~alu_legal(alu_op);
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scenarios plus randomized run against a behavioural EX/MEM model
module tb_ex_stage;
  logic clk = 0, rst = 0, in_valid = 0, stall = 0, flush = 0, we_control = 0;
  logic [1:0] mem_control = 0;
  logic [4:0] exe_control = 0, rs_addr = 0, rt_addr = 0, rd_addr = 0;
  logic [31:0] rs_data = 0, rt_data = 0, imm = 0, pc_plus4 = 0;
  logic exm_valid, exm_reg_write, exm_mem_rd, exm_mem_wr, exm_mem_to_reg, branch_taken, illegal_op, load_use_hazard;
  logic [31:0] exm_alu_result, exm_store_data, branch_target;
  logic [4:0] exm_wr_addr;
  int vectors = 0, errors = 0;

  typedef struct packed {
    logic valid, rw, rd, wr, m2r, bt, ill;
    logic [31:0] alu, sd, tgt;
    logic [4:0] wa;
  } exp_t;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .we_control(we_control), .mem_control(mem_control), .exe_control(exe_control),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .pc_plus4(pc_plus4), .exm_valid(exm_valid), .exm_alu_result(exm_alu_result),
    .exm_store_data(exm_store_data), .exm_wr_addr(exm_wr_addr), .exm_reg_write(exm_reg_write),
    .exm_mem_rd(exm_mem_rd), .exm_mem_wr(exm_mem_wr), .exm_mem_to_reg(exm_mem_to_reg),
    .branch_taken(branch_taken), .branch_target(branch_target), .illegal_op(illegal_op),
    .load_use_hazard(load_use_hazard)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic src, input logic rdst, input logic [1:0] mc,
                       input logic we, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [31:0] pc);
    in_valid = 1; stall = 0; flush = 0;
    exe_control = {op, src, rdst}; mem_control = mc; we_control = we;
    rs_addr = rs; rt_addr = rt; rd_addr = rd; rs_data = a; rt_data = b; imm = im; pc_plus4 = pc;
  endtask

  task automatic test_reset;
    #1 rst = 1;
    #1;
    vectors++; if ({exm_valid, exm_reg_write, exm_mem_rd, exm_mem_wr, exm_mem_to_reg, branch_taken, illegal_op} !== 7'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {exm_valid, exm_reg_write, exm_mem_rd, exm_mem_wr, exm_mem_to_reg, branch_taken, illegal_op}); end
    vectors++; if ({exm_alu_result, exm_store_data, branch_target, exm_wr_addr} !== '0) begin errors++; $display("FAIL reset_data got nonzero want 0"); end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_add_sub;
    issue(3'b001, 0, 1, 2'b00, 0, 1, 2, 3, 5, 7, 0, 0);
    tick;
    vectors++; if (exm_alu_result !== 12) begin errors++; $display("FAIL add_result got %0d want 12", exm_alu_result); end
    vectors++; if (exm_wr_addr !== 3 || exm_reg_write !== 1) begin errors++; $display("FAIL add_dest got %0d/%b want 3/1", exm_wr_addr, exm_reg_write); end
    issue(3'b010, 0, 1, 2'b00, 0, 3, 2, 4, 0, 2, 0, 0);
    tick;
    vectors++; if (exm_alu_result !== 10) begin errors++; $display("FAIL sub_fwd got %0d want 10", exm_alu_result); end
    vectors++; if (exm_wr_addr !== 4) begin errors++; $display("FAIL sub_dest got %0d want 4", exm_wr_addr); end
  endtask

  task automatic test_reset_mid;
    issue(3'b001, 0, 1, 2'b00, 0, 1, 2, 9, 1, 1, 0, 0);
    tick;
    vectors++; if (exm_valid !== 1) begin errors++; $display("FAIL midrst_pre got %b want 1", exm_valid); end
    #2 rst = 1;
    #1;
    vectors++; if (exm_valid !== 0 || exm_reg_write !== 0 || exm_alu_result !== 0 || exm_wr_addr !== 0) begin errors++; $display("FAIL midrst_async got v=%b rw=%b alu=%0h wa=%0d want 0", exm_valid, exm_reg_write, exm_alu_result, exm_wr_addr); end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_load_use;
    issue(3'b001, 1, 0, 2'b10, 1, 0, 5, 0, 0, 0, 32'h40, 0);
    tick;
    vectors++; if ({exm_mem_rd, exm_mem_to_reg, exm_reg_write, exm_mem_wr} !== 4'b1110 || exm_wr_addr !== 5) begin errors++; $display("FAIL lw_ctrl got %b wa=%0d want 1110 wa=5", {exm_mem_rd, exm_mem_to_reg, exm_reg_write, exm_mem_wr}, exm_wr_addr); end
    issue(3'b001, 0, 1, 2'b00, 0, 5, 1, 6, 100, 1, 0, 0);
    #1;
    vectors++; if (load_use_hazard !== 1) begin errors++; $display("FAIL lu_hazard got %b want 1", load_use_hazard); end
    tick;
    vectors++; if (exm_valid !== 0 || exm_reg_write !== 0) begin errors++; $display("FAIL lu_bubble got v=%b rw=%b want 0", exm_valid, exm_reg_write); end
    vectors++; if (load_use_hazard !== 0) begin errors++; $display("FAIL lu_release got %b want 0", load_use_hazard); end
    tick;
    vectors++; if (exm_alu_result !== 101 || exm_wr_addr !== 6) begin errors++; $display("FAIL lu_nofwd got %0d wa=%0d want 101 wa=6", exm_alu_result, exm_wr_addr); end
  endtask

  task automatic test_beq;
    issue(3'b110, 1, 0, 2'b00, 0, 1, 2, 0, 32'h10, 32'h10, 32'hFFFFFFFF, 32'h100);
    tick;
    vectors++; if (branch_taken !== 1 || branch_target !== 32'hFC) begin errors++; $display("FAIL beq_taken got %b tgt=%0h want 1 tgt=fc", branch_taken, branch_target); end
    vectors++; if (exm_reg_write !== 0 || exm_mem_wr !== 0 || exm_mem_rd !== 0) begin errors++; $display("FAIL beq_side got rw=%b want 0", exm_reg_write); end
    issue(3'b110, 1, 0, 2'b00, 0, 1, 2, 0, 32'h10, 32'h11, 32'hFFFFFFFF, 32'h100);
    tick;
    vectors++; if (branch_taken !== 0) begin errors++; $display("FAIL beq_not got %b want 0", branch_taken); end
  endtask

  task automatic test_stall_flush;
    issue(3'b001, 0, 1, 2'b00, 0, 1, 2, 7, 1, 2, 0, 0);
    stall = 1; flush = 1;
    tick;
    vectors++; if (exm_valid !== 0 || exm_reg_write !== 0) begin errors++; $display("FAIL stall_flush got v=%b rw=%b want 0", exm_valid, exm_reg_write); end
    issue(3'b001, 0, 1, 2'b00, 0, 1, 2, 8, 10, 20, 0, 0);
    tick;
    issue(3'b011, 0, 1, 2'b00, 0, 1, 2, 9, 32'hF0, 32'h3C, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++; if (exm_alu_result !== 30 || exm_wr_addr !== 8 || exm_valid !== 1) begin errors++; $display("FAIL stall_hold%0d got %0d wa=%0d want 30 wa=8", i, exm_alu_result, exm_wr_addr); end
    end
    stall = 0;
    tick;
    vectors++; if (exm_alu_result !== 32'h30 || exm_wr_addr !== 9) begin errors++; $display("FAIL stall_release got %0h wa=%0d want 30 wa=9", exm_alu_result, exm_wr_addr); end
  endtask

  task automatic test_illegal_r0;
    issue(3'b111, 0, 1, 2'b00, 0, 1, 2, 3, 1, 2, 0, 0);
    tick;
    vectors++; if (illegal_op !== 1 || exm_valid !== 0 || exm_reg_write !== 0) begin errors++; $display("FAIL illegal got ill=%b v=%b want 1/0", illegal_op, exm_valid); end
    issue(3'b001, 1, 0, 2'b00, 0, 1, 0, 0, 5, 0, 9, 0);
    tick;
    vectors++; if (illegal_op !== 0 || exm_valid !== 1 || exm_reg_write !== 0 || exm_alu_result !== 14) begin errors++; $display("FAIL addi_r0 got ill=%b v=%b rw=%b alu=%0d want 0/1/0/14", illegal_op, exm_valid, exm_reg_write, exm_alu_result); end
    issue(3'b010, 0, 1, 2'b00, 0, 0, 1, 2, 0, 3, 0, 0);
    tick;
    vectors++; if (exm_alu_result !== 32'hFFFFFFFD) begin errors++; $display("FAIL r0_nofwd got %0h want fffffffd", exm_alu_result); end
  endtask

  task automatic test_random;
    exp_t m, n;
    logic [2:0] op;
    logic [31:0] a, b, bb, res;
    logic hz, lg, beq, v;
    rst = 1; #1 rst = 0;
    m = '0;
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 9) != 0; stall = $urandom_range(0, 9) == 0; flush = $urandom_range(0, 19) == 0;
      we_control = 1'($urandom); mem_control = 2'($urandom); exe_control = 5'($urandom);
      rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3)); rd_addr = 5'($urandom_range(0, 3));
      rs_data = $urandom; rt_data = $urandom; imm = $urandom; pc_plus4 = $urandom;
      if ($urandom_range(0, 3) == 0) rt_data = rs_data;
      op = exe_control[4:2];
      beq = op == 3'd6;
      lg = op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
      hz = in_valid && m.valid && m.rd && m.wa != 0 &&
           (m.wa == rs_addr || (m.wa == rt_addr && (exe_control[0] || mem_control[0] || beq)));
      a = (m.valid && m.rw && !m.m2r && m.wa == rs_addr && rs_addr != 0) ? m.alu : rs_data;
      b = (m.valid && m.rw && !m.m2r && m.wa == rt_addr && rt_addr != 0) ? m.alu : rt_data;
      bb = (exe_control[1] && !beq) ? imm : b;
      res = op == 3'd1 ? a + bb : (op == 3'd2 || beq) ? a - bb : op == 3'd3 ? a & bb : a | bb;
      v = in_valid && !hz && lg;
      n = m;
      if (flush) begin
        n.valid = 0; n.rw = 0; n.rd = 0; n.wr = 0; n.m2r = 0; n.bt = 0; n.ill = 0;
      end else if (!stall) begin
        n.valid = v; n.alu = res; n.sd = b; n.wa = exe_control[0] ? rd_addr : rt_addr;
        n.rw = v && !mem_control[0] && !beq && n.wa != 0;
        n.rd = v && mem_control[1] && !beq; n.wr = v && mem_control[0] && !beq; n.m2r = v && we_control;
        n.bt = v && beq && a == b; n.tgt = pc_plus4 + imm * 4; n.ill = in_valid && !hz && !lg;
      end
      #1;
      vectors++; if (load_use_hazard !== hz) begin errors++; $display("FAIL rnd_hazard cyc %0d got %b want %b", i, load_use_hazard, hz); end
      tick;
      m = n;
      vectors++; if ({exm_valid, exm_reg_write, exm_mem_rd, exm_mem_wr, exm_mem_to_reg, branch_taken, illegal_op} !== {m.valid, m.rw, m.rd, m.wr, m.m2r, m.bt, m.ill}) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %b want %b", i, {exm_valid, exm_reg_write, exm_mem_rd, exm_mem_wr, exm_mem_to_reg, branch_taken, illegal_op}, {m.valid, m.rw, m.rd, m.wr, m.m2r, m.bt, m.ill}); end
      if (m.valid) begin
        vectors++; if (exm_alu_result !== m.alu || exm_store_data !== m.sd || exm_wr_addr !== m.wa) begin errors++; $display("FAIL rnd_data cyc %0d got %0h/%0h/%0d want %0h/%0h/%0d", i, exm_alu_result, exm_store_data, exm_wr_addr, m.alu, m.sd, m.wa); end
      end
      if (m.bt) begin
        vectors++; if (branch_target !== m.tgt) begin errors++; $display("FAIL rnd_target cyc %0d got %0h want %0h", i, branch_target, m.tgt); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_reset_mid;
    test_load_use;
    test_beq;
    test_stall_flush;
    test_illegal_r0;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
